// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar: FSM state encoding,
// default stream geometry and the one-hot decoder also used by the arbiter.
package stream_xbar_pkg;

    localparam int unsigned DEFAULT_NUM_REQUEST = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned MAX_REQUEST         = 32;
    localparam int unsigned IDX_W               = $clog2(MAX_REQUEST);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } mux_state_e;

    // OR of set-bit indices; exact for a one-hot vector, callers qualify one-hotness.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQUEST-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQUEST; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-stream output register: loads on request, clears valid
// when the downstream handshake completes without a replacement beat.
module axis_out_reg
    import stream_xbar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  last_q,  last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/axis_port_mux.sv
// Packet-locked AXI-stream mux: latches the arbiter's one-hot grant in IDLE,
// forwards the selected input through a registered output until its tlast.
module axis_port_mux
    import stream_xbar_pkg::*;
#(
    parameter  int unsigned NUM_REQUEST = DEFAULT_NUM_REQUEST,
    parameter  int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter  int unsigned MAX_BEATS   = 256,
    localparam int unsigned SEL_W       = $clog2(NUM_REQUEST),
    localparam int unsigned CNT_W       = $clog2(MAX_BEATS) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQUEST-1:0]            grant_i,
    input  logic [NUM_REQUEST-1:0]            s_tvalid_i,
    input  logic [NUM_REQUEST*DATA_WIDTH-1:0] s_tdata_i,
    input  logic [NUM_REQUEST-1:0]            s_tlast_i,
    output logic [NUM_REQUEST-1:0]            s_tready_o,
    output logic                              m_tvalid_o,
    output logic [DATA_WIDTH-1:0]             m_tdata_o,
    output logic                              m_tlast_o,
    input  logic                              m_tready_i,
    output logic [SEL_W-1:0]                  sel_o,
    output logic                              busy_o,
    output logic                              grant_err_o,
    output logic [CNT_W-1:0]                  beat_cnt_o
);

    mux_state_e               state_q, state_d;
    logic [SEL_W-1:0]         sel_q,   sel_d;
    logic [CNT_W-1:0]         cnt_q,   cnt_d;
    logic                     err_q,   err_d;

    logic                     m_tvalid;
    logic                     in_ready;
    logic                     accept;
    logic                     sel_valid;
    logic                     sel_last;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [MAX_REQUEST-1:0]   grant_ext;
    int                       grant_ones;

    // Input side: only the locked port may see ready, and only when the
    // output register is empty or draining this cycle.
    always_comb begin
        sel_valid  = s_tvalid_i[sel_q];
        sel_last   = s_tlast_i[sel_q];
        sel_data   = s_tdata_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
        in_ready   = (state_q == ST_LOCKED) && (!m_tvalid || m_tready_i);
        accept     = in_ready && sel_valid;
        s_tready_o = '0;
        s_tready_o[sel_q] = in_ready;
    end

    always_comb begin
        grant_ext  = MAX_REQUEST'(grant_i);
        grant_ones = $countones(grant_i);
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ones == 1) begin
                    sel_d   = SEL_W'(onehot_to_idx(grant_ext));
                    state_d = ST_LOCKED;
                end else if (grant_ones > 1) begin
                    err_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (accept && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (accept) begin
            if (sel_last) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_W'(MAX_BEATS)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .data_i  (sel_data),
        .last_i  (sel_last),
        .ready_i (m_tready_i),
        .valid_o (m_tvalid),
        .data_o  (m_tdata_o),
        .last_o  (m_tlast_o)
    );

    assign m_tvalid_o  = m_tvalid;
    assign sel_o       = sel_q;
    assign busy_o      = (state_q == ST_LOCKED);
    assign grant_err_o = err_q;
    assign beat_cnt_o  = cnt_q;

endmodule
